// File: rtl/wb_conmax_rf_p.sv
// Wishbone configuration register file with pass-through to the slave fabric.
// Serves NREG byte-writable registers, a sticky write-lock at index 63 and a commit strobe.
module wb_conmax_rf_p #(
    parameter logic [3:0] RF_ADDR = 4'hf,
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int SW   = DW / 8,
    parameter int NREG = 16,
    parameter int RW   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DW-1:0]        i_wb_data_i,
    output logic [DW-1:0]        i_wb_data_o,
    input  logic [AW-1:0]        i_wb_addr_i,
    input  logic [SW-1:0]        i_wb_sel_i,
    input  logic                 i_wb_we_i,
    input  logic                 i_wb_cyc_i,
    input  logic                 i_wb_stb_i,
    output logic                 i_wb_ack_o,
    output logic                 i_wb_err_o,
    output logic                 i_wb_rty_o,
    input  logic [DW-1:0]        e_wb_data_i,
    output logic [DW-1:0]        e_wb_data_o,
    output logic [AW-1:0]        e_wb_addr_o,
    output logic [SW-1:0]        e_wb_sel_o,
    output logic                 e_wb_we_o,
    output logic                 e_wb_cyc_o,
    output logic                 e_wb_stb_o,
    input  logic                 e_wb_ack_i,
    input  logic                 e_wb_err_i,
    input  logic                 e_wb_rty_i,
    output logic [NREG*RW-1:0]   conf_o,
    output logic                 lock_o,
    output logic                 upd_o,
    output logic [5:0]           upd_idx_o
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state, state_nxt;
    logic            rf_sel;
    logic [5:0]      idx;
    logic            is_lock;
    logic            is_mapped;
    logic            req_err;
    logic            rsp_err;
    logic            lock_q;
    logic            commit;
    logic            rf_ack;
    logic            rf_err;
    logic [DW-1:0]   rd_val;
    logic [DW-1:0]   rf_dout;
    logic [RW-1:0]   lane_mask;
    logic [RW-1:0]   conf_q [NREG];

    assign rf_sel    = i_wb_cyc_i & i_wb_stb_i & (i_wb_addr_i[AW-5:AW-8] == RF_ADDR);
    assign idx       = i_wb_addr_i[7:2];
    assign is_lock   = (idx == 6'd63);
    assign is_mapped = (int'(idx) < NREG);
    assign req_err   = (!is_mapped && !is_lock) || (i_wb_we_i && lock_q && !is_lock);
    assign commit    = (state == RESP) && rf_sel && i_wb_we_i && !rsp_err;

    // Read value captured at request time; erroring accesses return zero.
    always_comb begin
        rd_val = '0;
        if (!req_err) begin
            if (is_lock) begin
                rd_val[0] = lock_q;
            end else begin
                for (int k = 0; k < NREG; k++) begin
                    if (int'(idx) == k) begin
                        rd_val[RW-1:0] = conf_q[k];
                    end
                end
            end
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < RW; i++) begin
            lane_mask[i] = i_wb_sel_i[i/8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rf_sel) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rf_ack = 1'b0;
        rf_err = 1'b0;
        if (state == RESP) begin
            rf_ack = rf_sel & !rsp_err;
            rf_err = rf_sel & rsp_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_err <= 1'b0;
            rf_dout <= '0;
        end else if (state == IDLE && rf_sel) begin
            rsp_err <= req_err;
            rf_dout <= rd_val;
        end
    end

    // Writes commit at the end of the response cycle, so a master abort leaves state untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NREG; k++) begin
                conf_q[k] <= '0;
            end
            lock_q    <= 1'b0;
            upd_o     <= 1'b0;
            upd_idx_o <= '0;
        end else begin
            upd_o <= 1'b0;
            if (commit) begin
                if (is_lock) begin
                    if (i_wb_sel_i[0] && i_wb_data_i[0]) begin
                        lock_q <= 1'b1;
                    end
                end else if (is_mapped) begin
                    for (int k = 0; k < NREG; k++) begin
                        if (int'(idx) == k) begin
                            conf_q[k] <= (conf_q[k] & ~lane_mask) | (i_wb_data_i[RW-1:0] & lane_mask);
                        end
                    end
                    upd_o     <= 1'b1;
                    upd_idx_o <= idx;
                end
            end
        end
    end

    always_comb begin
        conf_o = '0;
        for (int k = 0; k < NREG; k++) begin
            conf_o[k*RW +: RW] = conf_q[k];
        end
    end

    assign lock_o      = lock_q;
    assign e_wb_addr_o = i_wb_addr_i;
    assign e_wb_sel_o  = i_wb_sel_i;
    assign e_wb_data_o = i_wb_data_i;
    assign e_wb_we_o   = i_wb_we_i;
    assign e_wb_stb_o  = i_wb_stb_i;
    assign e_wb_cyc_o  = i_wb_cyc_i & !rf_sel;
    assign i_wb_data_o = rf_sel ? rf_dout : e_wb_data_i;
    assign i_wb_ack_o  = rf_sel ? rf_ack  : e_wb_ack_i;
    assign i_wb_err_o  = rf_sel ? rf_err  : e_wb_err_i;
    assign i_wb_rty_o  = rf_sel ? 1'b0    : e_wb_rty_i;

endmodule
